// File: rtl/data_mem_slave.sv
// Word-organised data memory behind a req/gnt/rvalid port. The grant comes after WAIT_STATES cycles of held req.
// The response is registered and arrives one cycle after accept. The requester stalls until grant; there is no response backpressure.
module data_mem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_wr_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int                  IDX_W    = $clog2(DEPTH_WORDS);
  localparam int                  NB       = DATA_WIDTH / 8;
  localparam logic [3:0]          WAIT_CNT = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] LIMIT    = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic             gnt;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;

  // Grant depends only on req and the wait counter, never on address or data.
  assign gnt      = data_req_i && (wait_cnt_q == WAIT_CNT);
  assign accept   = gnt && !rst;
  assign in_range = ({1'b0, data_addr_i} < LIMIT);
  assign word_idx = data_addr_i[IDX_W+1:2];

  always_comb begin
    wait_cnt_d = 4'd0;
    rvalid_d   = accept;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (data_req_i && !gnt) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    // Writes and out-of-range reads answer with zero data; idle cycles hold the last response.
    if (accept) begin
      err_d   = !in_range;
      rdata_d = '0;
      if (!data_wr_i && in_range) begin
        rdata_d = mem_q[word_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Storage is not reset; contents survive rst and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (accept && data_wr_i && in_range) begin
      for (int n = 0; n < NB; n++) begin
        if (data_be_i[n]) begin
          mem_q[word_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed bench for data_mem_slave: one instance with no wait states, one with three.
module tb_data_mem_slave;

  logic        clk = 1'b0;
  logic        rst;

  logic        req0, wr0, gnt0, rv0, err0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  be0;

  logic        req3, wr3, gnt3, rv3, err3;
  logic [31:0] addr3, wd3, rd3;
  logic [3:0]  be3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .data_req_i(req0), .data_addr_i(addr0), .data_wr_i(wr0), .data_be_i(be0),
    .data_wdata_i(wd0), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_rdata_o(rd0), .data_err_o(err0)
  );

  data_mem_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .data_req_i(req3), .data_addr_i(addr3), .data_wr_i(wr3), .data_be_i(be3),
    .data_wdata_i(wd3), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_rdata_o(rd3), .data_err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer on the zero-wait instance; returns the response.
  task automatic single0(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
    req0 = 1'b1; wr0 = wr; addr0 = addr; be0 = be; wd0 = wd;
    @(negedge clk);
    chk("single_gnt", gnt0, 32'd1);
    tick;
    req0 = 1'b0;
    @(negedge clk);
    chk("single_rvalid", rv0, 32'd1);
    rd  = rd0;
    err = err0;
    tick;
  endtask

  logic [31:0] r;
  logic        e;
  logic [16:0] req_v, gnt_v, rv_v;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0;
    req3 = 1'b0; wr3 = 1'b0; addr3 = '0; be3 = '0; wd3 = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rvalid", rv0, 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_err", err0, 32'd0);
    chk("rst_gnt_idle", gnt0, 32'd0);
    chk("rst_rvalid3", rv3, 32'd0);
    tick;
    rst = 1'b0;
    tick;

    // Write then read the same word in back-to-back cycles
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; be0 = 4'hF; wd0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_wr_gnt", gnt0, 32'd1);
    tick;
    wr0 = 1'b0;
    @(negedge clk);
    chk("t1_rd_gnt", gnt0, 32'd1);
    chk("t1_wr_rvalid", rv0, 32'd1);
    chk("t1_wr_rdata", rd0, 32'd0);
    tick;
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_rd_rvalid", rv0, 32'd1);
    chk("t1_rd_rdata", rd0, 32'hDEADBEEF);
    chk("t1_rd_err", err0, 32'd0);
    tick;
    @(negedge clk);
    chk("t1_idle_rvalid", rv0, 32'd0);
    tick;

    // Byte lanes
    single0(1'b1, 32'h20, 4'hF, 32'h11223344, r, e);
    chk("bl_wr_rdata", r, 32'd0);
    single0(1'b1, 32'h20, 4'b0100, 32'h00AA0000, r, e);
    single0(1'b0, 32'h20, 4'h0, 32'h0, r, e);
    chk("bl_rdata", r, 32'h11AA3344);
    chk("bl_err", e, 32'd0);
    single0(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, r, e);
    single0(1'b0, 32'h20, 4'hF, 32'h0, r, e);
    chk("be0_rdata", r, 32'h11AA3344);

    // Streaming reads, one per cycle
    for (int i = 0; i < 8; i++) begin
      single0(1'b1, 32'(i * 4), 4'hF, 32'hA0000000 | 32'(i), r, e);
    end
    for (int i = 0; i < 8; i++) begin
      req0 = 1'b1; wr0 = 1'b0; addr0 = 32'(i * 4);
      @(negedge clk);
      chk($sformatf("stream_gnt%0d", i), gnt0, 32'd1);
      if (i > 0) begin
        chk($sformatf("stream_rvalid%0d", i - 1), rv0, 32'd1);
        chk($sformatf("stream_rdata%0d", i - 1), rd0, 32'hA0000000 | 32'(i - 1));
      end
      tick;
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("stream_rvalid7", rv0, 32'd1);
    chk("stream_rdata7", rd0, 32'hA0000007);
    tick;
    @(negedge clk);
    chk("stream_end_rvalid", rv0, 32'd0);
    tick;

    // Out of range accesses; 0x1000 aliases word 0 if upper bits were ignored
    single0(1'b1, 32'h1000, 4'hF, 32'h12345678, r, e);
    chk("oor_wr_err", e, 32'd1);
    single0(1'b0, 32'h1000, 4'hF, 32'h0, r, e);
    chk("oor_rd_err", e, 32'd1);
    chk("oor_rd_rdata", r, 32'd0);
    single0(1'b0, 32'h0, 4'hF, 32'h0, r, e);
    chk("oor_word0_rdata", r, 32'hA0000000);
    chk("oor_word0_err", e, 32'd0);
    single0(1'b0, 32'h80000004, 4'hF, 32'h0, r, e);
    chk("oor_msb_err", e, 32'd1);
    single0(1'b1, 32'hFFC, 4'hF, 32'h5A5A5A5A, r, e);
    single0(1'b0, 32'hFFC, 4'hF, 32'h0, r, e);
    chk("top_word_rdata", r, 32'h5A5A5A5A);
    chk("top_word_err", e, 32'd0);

    // Reset right after a read grant discards the response
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h20;
    @(negedge clk);
    chk("rstrd_gnt", gnt0, 32'd1);
    tick;
    rst = 1'b1; req0 = 1'b0;
    tick;
    @(negedge clk);
    chk("rstrd_rvalid", rv0, 32'd0);
    chk("rstrd_rdata", rd0, 32'd0);
    chk("rstrd_err", err0, 32'd0);
    // A grant coinciding with reset must not write
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; be0 = 4'hF; wd0 = 32'h0;
    tick;
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("rstwr_rvalid", rv0, 32'd0);
    tick;
    single0(1'b0, 32'h20, 4'hF, 32'h0, r, e);
    chk("rst_mem_kept", r, 32'h11AA3344);

    // Three wait states: write, immediate read, aborted request, restarted request
    req_v = 17'b0_1111_0110_1111_1111;
    gnt_v = 17'b0_1000_0000_1000_1000;
    rv_v  = 17'b1_0000_0001_0001_0000;
    for (int c = 0; c < 17; c++) begin
      req3 = req_v[c]; wr3 = (c < 4); addr3 = 32'h40; be3 = 4'hF; wd3 = 32'hCAFEF00D;
      @(negedge clk);
      chk($sformatf("w3_gnt_c%0d", c), gnt3, 32'(gnt_v[c]));
      chk($sformatf("w3_rvalid_c%0d", c), rv3, 32'(rv_v[c]));
      if (c == 4) chk("w3_wr_rdata", rd3, 32'd0);
      if (c == 8 || c == 16) chk($sformatf("w3_rdata_c%0d", c), rd3, 32'hCAFEF00D);
      tick;
    end
    req3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
